// File: rtl/shift_32_pkg.sv
// Shared constants for the 32-bit logical barrel shifter.
package shift_32_pkg;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SHAMT_W = 5;

    localparam logic LEFT  = 1'b1;
    localparam logic RIGHT = 1'b0;

endpackage

// File: rtl/shift_32_stage.sv
// One barrel stage: pass the input through, or shift it left by DIST with zero fill.
module shift_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIST  = 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             sel,
    output logic [WIDTH-1:0] dout_c
);

    assign dout_c = sel ? (din << DIST) : din;

endmodule

// File: rtl/shift_32.sv
// Registered 32-bit logical shifter; right shifts reuse the left barrel via bit reversal.
module shift_32 #(
    parameter int unsigned WIDTH   = shift_32_pkg::WIDTH,
    parameter int unsigned SHAMT_W = shift_32_pkg::SHAMT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] result,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] shift,
    input  logic             leftNotRight
);

    import shift_32_pkg::LEFT;

    logic [WIDTH-1:0] operand_rev;
    logic [WIDTH-1:0] barrel_in;
    logic [WIDTH-1:0] stage_q [SHAMT_W+1];
    logic [WIDTH-1:0] barrel_rev;
    logic [WIDTH-1:0] barrel_out;
    logic             overflow;
    logic [WIDTH-1:0] result_next;

    // Bit-reversal networks on the barrel input and output
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign operand_rev[i] = operand[WIDTH-1-i];
        assign barrel_rev[i]  = stage_q[SHAMT_W][WIDTH-1-i];
    end

    assign barrel_in  = (leftNotRight == LEFT) ? operand : operand_rev;
    assign stage_q[0] = barrel_in;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .din    (stage_q[k]),
            .sel    (shift[k]),
            .dout_c (stage_q[k+1])
        );
    end

    assign barrel_out = (leftNotRight == LEFT) ? stage_q[SHAMT_W] : barrel_rev;

    // Any amount at or beyond the data width shifts everything out
    assign overflow    = |shift[WIDTH-1:SHAMT_W];
    assign result_next = overflow ? '0 : barrel_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
        end else begin
            result <= result_next;
        end
    end

endmodule

// File: tb/tb_shift_32.sv
// Directed and random self-checking bench for shift_32.
`timescale 1ns/1ps
module tb_shift_32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] result;
    logic [31:0] operand = '0;
    logic [31:0] shift = '0;
    logic        leftNotRight = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    shift_32 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .result       (result),
        .operand      (operand),
        .shift        (shift),
        .leftNotRight (leftNotRight)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] op, input logic [31:0] sh,
                                              input logic dir);
        if (sh >= 32) return 32'h0;
        return dir ? (op << sh[4:0]) : (op >> sh[4:0]);
    endfunction

    // Drive one vector, clock it in, check the registered result
    task automatic run_vec(input string tag, input logic [31:0] op, input logic [31:0] sh,
                           input logic dir, input logic [31:0] exp);
        operand      = op;
        shift        = sh;
        leftNotRight = dir;
        @(posedge clk);
        #1;
        chk(tag, result, exp);
    endtask

    logic [31:0] bb_op  [4];
    logic [31:0] bb_sh  [4];
    logic        bb_dir [4];
    logic [31:0] bb_exp [4];

    initial begin
        // Reset state
        operand = 32'hDEAD_BEEF;
        shift   = 32'd1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Right shifts
        run_vec("r_1_by_1",      32'h0000_0001, 32'd1, 1'b0, 32'h0000_0000);
        run_vec("r_msb_by_1",    32'h8000_0000, 32'd1, 1'b0, 32'h4000_0000);
        run_vec("r_ones_by_1",   32'hFFFF_FFFF, 32'd1, 1'b0, 32'h7FFF_FFFF);
        run_vec("r_18_by_3",     32'h0000_0018, 32'd3, 1'b0, 32'h0000_0003);

        // Left shifts
        run_vec("l_2_by_2",      32'h0000_0002, 32'd2, 1'b1, 32'h0000_0008);
        run_vec("l_4_by_3",      32'h0000_0004, 32'd3, 1'b1, 32'h0000_0020);
        run_vec("l_1_by_5",      32'h0000_0001, 32'd5, 1'b1, 32'h0000_0020);
        run_vec("l_msb_by_1",    32'h8000_0000, 32'd1, 1'b1, 32'h0000_0000);
        run_vec("l_2_by_16",     32'h0000_0002, 32'd16, 1'b1, 32'h0002_0000);
        run_vec("l_ones_by_4",   32'hFFFF_FFFF, 32'd4, 1'b1, 32'hFFFF_FFF0);

        // Boundaries
        run_vec("l_by_0",        32'hA5C3_0F96, 32'd0, 1'b1, 32'hA5C3_0F96);
        run_vec("r_by_0",        32'hA5C3_0F96, 32'd0, 1'b0, 32'hA5C3_0F96);
        run_vec("r_msb_by_31",   32'h8000_0000, 32'd31, 1'b0, 32'h0000_0001);
        run_vec("l_1_by_31",     32'h0000_0001, 32'd31, 1'b1, 32'h8000_0000);
        run_vec("l_by_32",       32'hFFFF_FFFF, 32'd32, 1'b1, 32'h0000_0000);
        run_vec("r_by_32",       32'hFFFF_FFFF, 32'd32, 1'b0, 32'h0000_0000);
        run_vec("l_by_max",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000);
        run_vec("r_by_max",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000);
        run_vec("r_by_33",       32'hFFFF_FFFF, 32'd33, 1'b0, 32'h0000_0000);
        run_vec("l_by_bit5only", 32'h0000_0001, 32'h0000_0020, 1'b1, 32'h0000_0000);

        // Back-to-back: one-cycle latency, value holds until the following edge
        bb_op[0] = 32'h0000_00F0; bb_sh[0] = 32'd4;  bb_dir[0] = 1'b0; bb_exp[0] = 32'h0000_000F;
        bb_op[1] = 32'h0000_00F0; bb_sh[1] = 32'd4;  bb_dir[1] = 1'b1; bb_exp[1] = 32'h0000_0F00;
        bb_op[2] = 32'h1234_5678; bb_sh[2] = 32'd8;  bb_dir[2] = 1'b1; bb_exp[2] = 32'h3456_7800;
        bb_op[3] = 32'h1234_5678; bb_sh[3] = 32'd12; bb_dir[3] = 1'b0; bb_exp[3] = 32'h0001_2345;
        for (int i = 0; i < 4; i++) begin
            operand      = bb_op[i];
            shift        = bb_sh[i];
            leftNotRight = bb_dir[i];
            @(posedge clk);
            #1;
            chk($sformatf("b2b_%0d", i), result, bb_exp[i]);
        end
        operand = 32'hFFFF_FFFF;
        shift   = 32'd0;
        #7;
        chk("b2b_hold", result, bb_exp[3]);

        // Asynchronous reset mid-stream
        run_vec("pre_reset", 32'h0000_0002, 32'd2, 1'b1, 32'h0000_0008);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async", result, 32'h0);
        operand      = 32'h0000_00FF;
        shift        = 32'd0;
        leftNotRight = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_held_edge", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("post_reset", 32'h0000_0018, 32'd3, 1'b0, 32'h0000_0003);

        // Random against reference model
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] op;
            logic [31:0] sh;
            logic        dir;
            op  = $urandom;
            sh  = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 40));
            dir = 1'($urandom_range(0, 1));
            run_vec("random", op, sh, dir, ref_shift(op, sh, dir));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_32.md
SHIFT_32 -- requirements
Module: shift_32

Interface
REQ-001 Parameter: WIDTH, default 32, data width; only 32 is required to be supported.
REQ-002 Parameter: SHAMT_W, default 5, number of shift-amount bits decoded by the barrel stages (log2 WIDTH).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: result  output  32  registered shift result.
REQ-006 Port: operand  input  32  value to be shifted.
REQ-007 Port: shift  input  32  unsigned shift amount.
REQ-008 Port: leftNotRight  input  1  1 = shift left, 0 = shift right.
REQ-009 Port order SHALL be clk, rst_n, result, operand, shift, leftNotRight.

Function
REQ-010 The shift SHALL be logical in both directions: vacated bit positions are filled with 0; there is no sign extension.
REQ-011 When leftNotRight=1 the next result SHALL be (operand << shift) truncated to 32 bits.
REQ-012 When leftNotRight=0 the next result SHALL be (operand >> shift).
REQ-013 Shift amount 0 SHALL return operand unchanged in either direction.
REQ-014 Any shift value >= 32, meaning any of bits [31:5] nonzero, SHALL produce result = 0.
REQ-015 The shift SHALL be computed by a five-stage logarithmic barrel: stage k shifts by 2^k when shift[k]=1, for k = 0..4.
REQ-016 Right shifts SHALL be implemented by bit-reversing the operand, left-shifting, then bit-reversing the output, so a single left-shift barrel serves both directions.
REQ-017 The datapath from operand/shift/leftNotRight to the result register SHALL be purely combinational.
REQ-018 Latency SHALL be exactly 1 cycle: inputs sampled on rising edge N appear on result after edge N and hold until edge N+1.
REQ-019 A new operation SHALL be accepted every cycle; there is no handshake and no stall.
REQ-020 result SHALL change only on a rising clk edge or on reset assertion.

Reset
REQ-021 When rst_n is low, result SHALL go to 32'h0000_0000 immediately, without waiting for a clock edge.
REQ-022 While rst_n is low, result SHALL stay 0 regardless of clock activity or input values.
REQ-023 On rst_n deassertion, the first rising edge SHALL capture the current inputs normally.
REQ-024 Reset asserted mid-stream SHALL discard the pending result; there is no other state.

Structure
REQ-025 A shared package SHALL hold the constants WIDTH=32 and SHAMT_W=5, and the direction encodings LEFT=1 and RIGHT=0.
REQ-026 One sub-module, shift_stage, SHALL implement a single barrel stage: a 32-bit 2:1 mux selecting between the input and the input shifted left by parameter DIST with zero fill.
REQ-027 shift_32 SHALL instantiate five shift_stage instances (DIST = 1, 2, 4, 8, 16), plus the bit-reversal muxes, the >=32 zeroing logic and the output register.

Verification
REQ-028 Right shifts: operand=1, shift=1 -> 0; 0x8000_0000 >> 1 -> 0x4000_0000; 0xFFFF_FFFF >> 1 -> 0x7FFF_FFFF (confirms zero fill); 0x18 >> 3 -> 0x3.
REQ-029 Left shifts: 0x2 << 2 -> 0x8; 0x4 << 3 -> 0x20; 1 << 5 -> 0x20; 0x8000_0000 << 1 -> 0 (top bit drops); 0x2 << 16 -> 0x0002_0000.
REQ-030 Boundaries: shift=0 returns operand in both directions; shift=31 on 0x8000_0000 right -> 1; shift=32 and shift=0xFFFF_FFFF -> 0 in both directions.
REQ-031 Latency: apply back-to-back distinct vectors on consecutive cycles -> each result appears exactly one cycle later with no bubbles.
REQ-032 Reset: assert rst_n low between clock edges with result nonzero -> result goes to 0 before the next edge; after release, the next edge loads the correct result.
REQ-033 A random test of at least 10,000 vectors SHALL match a reference model of logical shift with the >=32 -> 0 rule.
